kv_db_responder: RTL

- Database end of the key/flag lookup interface driven by eth_encap.
- Accepts one request per cycle on in_key/in_flag/in_valid and answers each with exactly one out_valid/out_flag pulse at fixed latency.
- Backed by a small fully associative key table; no backpressure exists on the interface, so the block is fully pipelined.
- Sits in the clk156 domain beside eth_top and replaces the external key-value stub.

---
 rtl/kv_pkg.sv | 12 +
 rtl/kv_match_array.sv | 34 +++
 rtl/kv_db_responder.sv | 104 ++++++++++
 3 files changed

// File: rtl/kv_pkg.sv
// kv_pkg: opcode and response constants shared by the key/flag lookup interface.
package kv_pkg;
   localparam int FLAG_W = 4;
   localparam logic [FLAG_W-1:0] OP_GET     = 4'h1;
   localparam logic [FLAG_W-1:0] OP_SET     = 4'h2;
   localparam logic [FLAG_W-1:0] OP_DEL     = 4'h4;
   localparam logic [FLAG_W-1:0] RSP_HIT    = 4'h1;
   localparam logic [FLAG_W-1:0] RSP_MISS   = 4'h2;
   localparam logic [FLAG_W-1:0] RSP_SET_OK = 4'h4;
   localparam logic [FLAG_W-1:0] RSP_DEL_OK = 4'h5;
   localparam logic [FLAG_W-1:0] RSP_ERR    = 4'hF;
endpackage

// File: rtl/kv_match_array.sv
// kv_match_array: parallel key compare with lowest-index hit and first-free priority encode.
module kv_match_array #(
   parameter int KEY_SIZE = 96,
   parameter int ENTRIES  = 16,
   localparam int IDX_W   = $clog2(ENTRIES)
) (
   input  logic [ENTRIES-1:0][KEY_SIZE-1:0] i_keys,
   input  logic [ENTRIES-1:0]               i_valid,
   input  logic [KEY_SIZE-1:0]              i_key,
   output logic                             o_hit,
   output logic [IDX_W-1:0]                 o_hit_idx,
   output logic                             o_free_avail,
   output logic [IDX_W-1:0]                 o_free_idx,
   output logic                             o_full
);
   // Scanning high to low lets the lowest index overwrite last, giving it priority.
   always_comb begin
      o_hit        = 1'b0;
      o_hit_idx    = '0;
      o_free_avail = 1'b0;
      o_free_idx   = '0;
      for (int i = ENTRIES - 1; i >= 0; i--) begin
         if (i_valid[i] && i_keys[i] == i_key) begin
            o_hit     = 1'b1;
            o_hit_idx = IDX_W'(i);
         end
         if (!i_valid[i]) begin
            o_free_avail = 1'b1;
            o_free_idx   = IDX_W'(i);
         end
      end
   end
   assign o_full = &i_valid;
endmodule

// File: rtl/kv_db_responder.sv
// kv_db_responder: two-stage pipelined key table answering GET/SET/DEL at fixed latency 2.
// Optional hit/miss counters on debug when KV_RESP_STATS_EN is defined.
module kv_db_responder
   import kv_pkg::*;
#(
   parameter int KEY_SIZE = 96,
   parameter int ENTRIES  = 16,
   localparam int IDX_W   = $clog2(ENTRIES)
) (
   input  logic                clk156,
   input  logic                eth_rst,
   input  logic [KEY_SIZE-1:0] in_key,
   input  logic [FLAG_W-1:0]   in_flag,
   input  logic                in_valid,
   output logic                out_valid,
   output logic [FLAG_W-1:0]   out_flag,
   output logic [IDX_W:0]      occupancy,
   output logic [7:0]          debug
);
   logic                             r_s1_valid;
   logic [KEY_SIZE-1:0]              r_s1_key;
   logic [FLAG_W-1:0]                r_s1_flag;
   logic [ENTRIES-1:0][KEY_SIZE-1:0] r_keys;
   logic [ENTRIES-1:0]               r_valid;
   logic [IDX_W-1:0]                 r_rr_ptr;
   logic                             r_out_valid;
   logic [FLAG_W-1:0]                r_out_flag;
   logic [IDX_W:0]                   r_occ;
   logic                             w_hit, w_free_avail, w_full;
   logic [IDX_W-1:0]                 w_hit_idx, w_free_idx, w_wr_idx;
   logic                             w_get, w_set, w_del_op, w_wr_en, w_del;
   logic [FLAG_W-1:0]                w_rsp;

   kv_match_array #(.KEY_SIZE(KEY_SIZE), .ENTRIES(ENTRIES)) u_match (
      .i_keys      (r_keys),
      .i_valid     (r_valid),
      .i_key       (r_s1_key),
      .o_hit       (w_hit),
      .o_hit_idx   (w_hit_idx),
      .o_free_avail(w_free_avail),
      .o_free_idx  (w_free_idx),
      .o_full      (w_full)
   );

   always_comb begin
      w_get    = r_s1_flag == OP_GET;
      w_set    = r_s1_flag == OP_SET;
      w_del_op = r_s1_flag == OP_DEL;
      w_rsp    = w_get ? (w_hit ? RSP_HIT : RSP_MISS) :
                 w_set ? RSP_SET_OK :
                 w_del_op ? (w_hit ? RSP_DEL_OK : RSP_MISS) : RSP_ERR;
      w_wr_en  = r_s1_valid && w_set && !w_hit;
      w_del    = r_s1_valid && w_del_op && w_hit;
      w_wr_idx = w_full ? r_rr_ptr : w_free_idx;
   end

   // Key storage and S1 payload carry no reset; validity alone qualifies them.
   always_ff @(posedge clk156) begin
      r_s1_key  <= in_key;
      r_s1_flag <= in_flag;
      if (w_wr_en) r_keys[w_wr_idx] <= r_s1_key;
   end

   always_ff @(posedge clk156) begin
      if (eth_rst) begin
         r_s1_valid  <= 1'b0;
         r_valid     <= '0;
         r_rr_ptr    <= '0;
         r_out_valid <= 1'b0;
         r_out_flag  <= '0;
         r_occ       <= '0;
      end else begin
         r_s1_valid  <= in_valid;
         r_out_valid <= r_s1_valid;
         if (r_s1_valid) r_out_flag <= w_rsp;
         if (w_wr_en) r_valid[w_wr_idx] <= 1'b1;
         if (w_del) r_valid[w_hit_idx] <= 1'b0;
         if (w_wr_en && w_free_avail) r_occ <= r_occ + (IDX_W+1)'(1);
         else if (w_del) r_occ <= r_occ - (IDX_W+1)'(1);
         if (w_wr_en && w_full) r_rr_ptr <= r_rr_ptr + IDX_W'(1);
      end
   end

   assign out_valid = r_out_valid;
   assign out_flag  = r_out_flag;
   assign occupancy = r_occ;

`ifdef KV_RESP_STATS_EN
   logic [15:0] r_hit_cnt, r_miss_cnt;
   always_ff @(posedge clk156) begin
      if (eth_rst) begin
         r_hit_cnt  <= '0;
         r_miss_cnt <= '0;
      end else begin
         if (r_s1_valid && w_get && w_hit && r_hit_cnt != 16'hFFFF) r_hit_cnt <= r_hit_cnt + 16'd1;
         if (r_s1_valid && (w_get || w_del_op) && !w_hit && r_miss_cnt != 16'hFFFF)
            r_miss_cnt <= r_miss_cnt + 16'd1;
      end
   end
   assign debug = {r_hit_cnt[3:0], r_miss_cnt[3:0]};
`else
   assign debug = 8'(r_occ);
`endif
endmodule
